// File: rtl/leitor_caminho.sv
// -----------------------------------------------------------------------------
// leitor_caminho
// Reverses the node path produced by the anterior-memory walk. Nodes arrive
// destino-first and are pushed into an internal LIFO; once the path is
// complete they are popped and streamed out fonte-first on a valid/ready port.
//
// Ports
//   clk                 system clock, all state on the rising edge
//   rst_n               asynchronous active-low reset
//   iniciar_in          pulse: new search started; clears the block, arms capture
//   no_valido_in        strobe: a path node is present on no_endereco_in
//   no_endereco_in      path node address (destino first, fonte last)
//   caminho_pronto_in   pulse: path reconstruction finished
//   saida_valido_out    output node valid
//   saida_endereco_out  output node address (fonte first)
//   saida_ultimo_out    marks the final output node (destino)
//   saida_pronto_in     consumer ready
//   ocupado_out         high while not idle
//   tamanho_out         number of nodes captured, held until next iniciar_in
//   overflow_out        sticky: a node was dropped because the LIFO was full
// -----------------------------------------------------------------------------
module leitor_caminho #(
   parameter int ADDR_WIDTH  = 10,
   parameter int MAX_CAMINHO = 64,
   parameter int CONT_WIDTH  = $clog2(MAX_CAMINHO + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  iniciar_in,
   input  logic                  no_valido_in,
   input  logic [ADDR_WIDTH-1:0] no_endereco_in,
   input  logic                  caminho_pronto_in,
   output logic                  saida_valido_out,
   output logic [ADDR_WIDTH-1:0] saida_endereco_out,
   output logic                  saida_ultimo_out,
   input  logic                  saida_pronto_in,
   output logic                  ocupado_out,
   output logic [CONT_WIDTH-1:0] tamanho_out,
   output logic                  overflow_out
);

   localparam int IDX_WIDTH = (MAX_CAMINHO > 1) ? $clog2(MAX_CAMINHO) : 1;

   localparam logic [1:0] OCIOSO  = 2'd0;
   localparam logic [1:0] CAPTURA = 2'd1;
   localparam logic [1:0] ENVIO   = 2'd2;

   localparam logic [CONT_WIDTH-1:0] ZERO_C = {CONT_WIDTH{1'b0}};
   localparam logic [CONT_WIDTH-1:0] ONE_C  = CONT_WIDTH'(1);
   localparam logic [CONT_WIDTH-1:0] MAX_C  = CONT_WIDTH'(MAX_CAMINHO);

   logic [ADDR_WIDTH-1:0] mem_q [MAX_CAMINHO];

   logic [1:0]            state_q,   state_d;
   logic [CONT_WIDTH-1:0] ptr_q,     ptr_d;
   logic [CONT_WIDTH-1:0] tamanho_q, tamanho_d;
   logic                  overflow_q, overflow_d;
   logic                  valido_q,  valido_d;
   logic [ADDR_WIDTH-1:0] endereco_q, endereco_d;
   logic                  ultimo_q,  ultimo_d;
   logic                  ocupado_q, ocupado_d;
   logic                  wr_en_s;
   logic [CONT_WIDTH-1:0] ptr_dec_s;
   logic [IDX_WIDTH-1:0]  wr_idx_s;
   logic [IDX_WIDTH-1:0]  rd_idx_s;

   // The pointer only ever indexes the array while below MAX_CAMINHO (write)
   // or above zero (read), so the truncated index is always in range.
   assign ptr_dec_s = ptr_q - ONE_C;
   assign wr_idx_s  = ptr_q[IDX_WIDTH-1:0];
   assign rd_idx_s  = ptr_dec_s[IDX_WIDTH-1:0];

   // Next-state logic: control FSM, LIFO pointer, counters and output register.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      tamanho_d  = tamanho_q;
      overflow_d = overflow_q;
      valido_d   = valido_q;
      endereco_d = endereco_q;
      ultimo_d   = ultimo_q;
      wr_en_s    = 1'b0;

      if (iniciar_in) begin
         // Restart wins over everything, including an ENVIO in progress.
         state_d    = CAPTURA;
         ptr_d      = ZERO_C;
         tamanho_d  = ZERO_C;
         overflow_d = 1'b0;
         valido_d   = 1'b0;
      end else begin
         case (state_q)
            OCIOSO: begin
               state_d = OCIOSO;
            end
            CAPTURA: begin
               if (no_valido_in) begin
                  if (ptr_q < MAX_C) begin
                     wr_en_s = 1'b1;
                     ptr_d   = ptr_q + ONE_C;
                     if (tamanho_q < MAX_C) begin
                        tamanho_d = tamanho_q + ONE_C;
                     end else begin
                        tamanho_d = tamanho_q;
                     end
                  end else begin
                     overflow_d = 1'b1;
                  end
               end else begin
                  ptr_d = ptr_q;
               end
               // ptr_d already includes a node strobed in this same cycle.
               if (caminho_pronto_in) begin
                  if (ptr_d != ZERO_C) begin
                     state_d = ENVIO;
                  end else begin
                     state_d = OCIOSO;
                  end
               end else begin
                  state_d = CAPTURA;
               end
            end
            ENVIO: begin
               // Load when the output register is empty or being consumed.
               if (!valido_q || saida_pronto_in) begin
                  if (ptr_q != ZERO_C) begin
                     valido_d   = 1'b1;
                     endereco_d = mem_q[rd_idx_s];
                     ultimo_d   = (ptr_q == ONE_C);
                     ptr_d      = ptr_dec_s;
                  end else begin
                     valido_d = 1'b0;
                     state_d  = OCIOSO;
                  end
               end else begin
                  valido_d = valido_q;
               end
            end
            default: begin
               state_d  = OCIOSO;
               valido_d = 1'b0;
            end
         endcase
      end

      ocupado_d = (state_d != OCIOSO);
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= OCIOSO;
         ptr_q      <= ZERO_C;
         tamanho_q  <= ZERO_C;
         overflow_q <= 1'b0;
         valido_q   <= 1'b0;
         endereco_q <= {ADDR_WIDTH{1'b0}};
         ultimo_q   <= 1'b0;
         ocupado_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         tamanho_q  <= tamanho_d;
         overflow_q <= overflow_d;
         valido_q   <= valido_d;
         endereco_q <= endereco_d;
         ultimo_q   <= ultimo_d;
         ocupado_q  <= ocupado_d;
      end
   end

   // LIFO storage; contents are only meaningful below ptr_q, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_q[wr_idx_s] <= no_endereco_in;
      end
   end

   assign saida_valido_out   = valido_q;
   assign saida_endereco_out = endereco_q;
   assign saida_ultimo_out   = ultimo_q;
   assign ocupado_out        = ocupado_q;
   assign tamanho_out        = tamanho_q;
   assign overflow_out       = overflow_q;

endmodule

// File: tb/tb_leitor_caminho.sv
// -----------------------------------------------------------------------------
// tb_leitor_caminho
// Self-checking bench for leitor_caminho with a small LIFO (MAX_CAMINHO=4).
// Expected output nodes are pushed to a scoreboard queue when a path is sent
// and popped by a monitor whenever the DUT completes an output transfer.
// -----------------------------------------------------------------------------
module tb_leitor_caminho;

   localparam int AW  = 10;
   localparam int MAX = 4;
   localparam int CW  = 3;

   logic          clk;
   logic          rst_n;
   logic          iniciar_in;
   logic          no_valido_in;
   logic [AW-1:0] no_endereco_in;
   logic          caminho_pronto_in;
   logic          saida_valido_out;
   logic [AW-1:0] saida_endereco_out;
   logic          saida_ultimo_out;
   logic          saida_pronto_in;
   logic          ocupado_out;
   logic [CW-1:0] tamanho_out;
   logic          overflow_out;

   int errors = 0;
   int checks = 0;

   logic [AW:0]   sb[$];        // {ultimo, endereco}
   logic [AW-1:0] path_nodes[$];
   logic          stall_chk = 1'b0;
   logic          prev_stall = 1'b0;
   logic [AW:0]   prev_out = '0;

   leitor_caminho #(
      .ADDR_WIDTH (AW),
      .MAX_CAMINHO(MAX),
      .CONT_WIDTH (CW)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .iniciar_in        (iniciar_in),
      .no_valido_in      (no_valido_in),
      .no_endereco_in    (no_endereco_in),
      .caminho_pronto_in (caminho_pronto_in),
      .saida_valido_out  (saida_valido_out),
      .saida_endereco_out(saida_endereco_out),
      .saida_ultimo_out  (saida_ultimo_out),
      .saida_pronto_in   (saida_pronto_in),
      .ocupado_out       (ocupado_out),
      .tamanho_out       (tamanho_out),
      .overflow_out      (overflow_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output monitor: inputs change at posedge+1, so at negedge the ready value
   // is the one the next rising edge will sample.
   always @(negedge clk) begin
      if (rst_n) begin
         if (stall_chk && prev_stall) begin
            checks++;
            if (!saida_valido_out || {saida_ultimo_out, saida_endereco_out} !== prev_out) begin
               errors++;
               $display("FAIL hold_stable: got v=%0b %h required v=1 %h",
                        saida_valido_out, {saida_ultimo_out, saida_endereco_out}, prev_out);
            end
         end
         prev_stall = saida_valido_out && !saida_pronto_in;
         prev_out   = {saida_ultimo_out, saida_endereco_out};
         if (saida_valido_out && saida_pronto_in) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got %h required none", saida_endereco_out);
            end else begin
               logic [AW:0] exp;
               exp = sb.pop_front();
               if ({saida_ultimo_out, saida_endereco_out} !== exp) begin
                  errors++;
                  $display("FAIL output_node: got ult=%0b addr=%h required ult=%0b addr=%h",
                           saida_ultimo_out, saida_endereco_out, exp[AW], exp[AW-1:0]);
               end
            end
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Starts a path, sends path_nodes with pronto on the last node, and
   // pushes the reversed, capacity-limited path into the scoreboard.
   task automatic send_path;
      logic [AW-1:0] lifo[$];
      int n;
      n = path_nodes.size();
      iniciar_in = 1'b1;
      step();
      iniciar_in = 1'b0;
      checks++;
      if (ocupado_out !== 1'b1 || saida_valido_out !== 1'b0 || tamanho_out !== 3'd0 || overflow_out !== 1'b0) begin
         errors++;
         $display("FAIL after_iniciar: got ocup=%0b v=%0b tam=%0d ovf=%0b required 1 0 0 0",
                  ocupado_out, saida_valido_out, tamanho_out, overflow_out);
      end
      if (n == 0) begin
         caminho_pronto_in = 1'b1;
         step();
         caminho_pronto_in = 1'b0;
      end else begin
         for (int i = 0; i < n; i++) begin
            no_valido_in      = 1'b1;
            no_endereco_in    = path_nodes[i];
            caminho_pronto_in = (i == n - 1);
            if (lifo.size() < MAX) lifo.push_back(path_nodes[i]);
            step();
         end
         no_valido_in      = 1'b0;
         caminho_pronto_in = 1'b0;
         for (int j = lifo.size() - 1; j >= 0; j--) sb.push_back({(j == 0), lifo[j]});
         checks++;
         if (tamanho_out !== CW'(lifo.size()) || overflow_out !== (n > MAX)) begin
            errors++;
            $display("FAIL capture_counts: got tam=%0d ovf=%0b required tam=%0d ovf=%0b",
                     tamanho_out, overflow_out, lifo.size(), (n > MAX));
         end
         checks++;
         if (saida_valido_out !== 1'b0 || ocupado_out !== 1'b1) begin
            errors++;
            $display("FAIL envio_entry: got v=%0b ocup=%0b required v=0 ocup=1",
                     saida_valido_out, ocupado_out);
         end
      end
   endtask

   // Drives ready (mode 0: always high, mode 1: 1,0,0 repeating) until the
   // scoreboard empties and the block idles; counts cycles with valid high.
   task automatic wait_drain(input int mode, output int vcycles);
      bit done;
      done = 1'b0;
      vcycles = 0;
      for (int cyc = 0; cyc < 60 && !done; cyc++) begin
         saida_pronto_in = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         step();
         if (saida_valido_out) vcycles++;
         if (!saida_valido_out && !ocupado_out && sb.size() == 0) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending required 0 and idle", sb.size());
      end
      saida_pronto_in = 1'b1;
   endtask

   task automatic test_reset;
      checks++;
      if (saida_valido_out !== 1'b0 || saida_endereco_out !== 10'd0 || saida_ultimo_out !== 1'b0 ||
          ocupado_out !== 1'b0 || tamanho_out !== 3'd0 || overflow_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: got v=%0b a=%h u=%0b ocup=%0b tam=%0d ovf=%0b required all 0",
                  saida_valido_out, saida_endereco_out, saida_ultimo_out, ocupado_out, tamanho_out, overflow_out);
      end
      // Idle block must ignore nodes and pronto.
      no_valido_in = 1'b1; no_endereco_in = 10'h155; caminho_pronto_in = 1'b1;
      step(); step();
      no_valido_in = 1'b0; caminho_pronto_in = 1'b0;
      checks++;
      if (ocupado_out !== 1'b0 || tamanho_out !== 3'd0 || saida_valido_out !== 1'b0) begin
         errors++;
         $display("FAIL idle_ignores: got ocup=%0b tam=%0d v=%0b required 0 0 0",
                  ocupado_out, tamanho_out, saida_valido_out);
      end
   endtask

   task automatic test_basic;
      int vc;
      path_nodes = '{10'h02A, 10'h015, 10'h007, 10'h003};
      saida_pronto_in = 1'b1;
      send_path();
      step();
      checks++;
      if (saida_valido_out !== 1'b1 || saida_endereco_out !== 10'h003 || saida_ultimo_out !== 1'b0) begin
         errors++;
         $display("FAIL first_latency: got v=%0b a=%h u=%0b required v=1 a=003 u=0",
                  saida_valido_out, saida_endereco_out, saida_ultimo_out);
      end
      wait_drain(0, vc);
      checks++;
      if (vc + 1 != 4) begin
         errors++;
         $display("FAIL throughput: got %0d valid cycles required 4", vc + 1);
      end
      checks++;
      if (tamanho_out !== 3'd4 || ocupado_out !== 1'b0 || saida_valido_out !== 1'b0) begin
         errors++;
         $display("FAIL basic_end: got tam=%0d ocup=%0b v=%0b required 4 0 0",
                  tamanho_out, ocupado_out, saida_valido_out);
      end
   endtask

   task automatic test_backpressure;
      int vc;
      path_nodes = '{10'h02A, 10'h015, 10'h007, 10'h003};
      saida_pronto_in = 1'b0;
      stall_chk = 1'b1;
      send_path();
      wait_drain(1, vc);
      stall_chk = 1'b0;
      checks++;
      if (vc < 4) begin
         errors++;
         $display("FAIL backpressure_cycles: got %0d valid cycles required at least 4", vc);
      end
   endtask

   task automatic test_overflow;
      int vc;
      path_nodes = '{10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6};
      saida_pronto_in = 1'b1;
      send_path();
      wait_drain(0, vc);
      checks++;
      if (overflow_out !== 1'b1 || tamanho_out !== 3'd4 || vc != 4) begin
         errors++;
         $display("FAIL overflow_end: got ovf=%0b tam=%0d vcyc=%0d required 1 4 4",
                  overflow_out, tamanho_out, vc);
      end
   endtask

   task automatic test_empty;
      bit seen;
      path_nodes = {};
      saida_pronto_in = 1'b1;
      send_path();
      checks++;
      if (ocupado_out !== 1'b0 || saida_valido_out !== 1'b0) begin
         errors++;
         $display("FAIL empty_idle: got ocup=%0b v=%0b required 0 0", ocupado_out, saida_valido_out);
      end
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (saida_valido_out) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL empty_no_valid: got valid=1 required never");
      end
   endtask

   task automatic test_abort;
      int vc;
      path_nodes = '{10'h031, 10'h032, 10'h033};
      saida_pronto_in = 1'b0;
      send_path();
      // Only the first node is consumed before the restart.
      sb.delete();
      sb.push_back({1'b0, 10'h033});
      step();
      saida_pronto_in = 1'b1;
      step();
      saida_pronto_in = 1'b0;
      checks++;
      if (sb.size() != 0 || saida_valido_out !== 1'b1 || saida_endereco_out !== 10'h032) begin
         errors++;
         $display("FAIL abort_first: got pend=%0d v=%0b a=%h required 0 1 032",
                  sb.size(), saida_valido_out, saida_endereco_out);
      end
      path_nodes = '{10'h010, 10'h011};
      send_path();
      wait_drain(0, vc);
      checks++;
      if (tamanho_out !== 3'd2 || vc != 2) begin
         errors++;
         $display("FAIL abort_new_path: got tam=%0d vcyc=%0d required 2 2", tamanho_out, vc);
      end
   endtask

   task automatic test_async_reset;
      iniciar_in = 1'b1;
      step();
      iniciar_in = 1'b0;
      no_valido_in = 1'b1; no_endereco_in = 10'h0AA;
      step();
      no_endereco_in = 10'h0BB;
      step();
      no_valido_in = 1'b0;
      checks++;
      if (tamanho_out !== 3'd2 || ocupado_out !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: got tam=%0d ocup=%0b required 2 1", tamanho_out, ocupado_out);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (saida_valido_out !== 1'b0 || saida_endereco_out !== 10'd0 || saida_ultimo_out !== 1'b0 ||
          ocupado_out !== 1'b0 || tamanho_out !== 3'd0 || overflow_out !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got v=%0b a=%h u=%0b ocup=%0b tam=%0d ovf=%0b required all 0",
                  saida_valido_out, saida_endereco_out, saida_ultimo_out, ocupado_out, tamanho_out, overflow_out);
      end
      #3;
      rst_n = 1'b1;
      step();
      checks++;
      if (ocupado_out !== 1'b0 || tamanho_out !== 3'd0) begin
         errors++;
         $display("FAIL after_reset_idle: got ocup=%0b tam=%0d required 0 0", ocupado_out, tamanho_out);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      iniciar_in = 1'b0;
      no_valido_in = 1'b0;
      no_endereco_in = 10'd0;
      caminho_pronto_in = 1'b0;
      saida_pronto_in = 1'b1;
      #12;
      rst_n = 1'b1;
      step();
      test_reset();
      test_basic();
      test_backpressure();
      test_overflow();
      test_empty();
      test_abort();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover: got %0d pending required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/leitor_caminho.md
# leitor_caminho

Path output reverser downstream of the path-reconstruction stage. It captures the path nodes emitted by the anterior-memory walk, which arrive destino-first, into an internal LIFO. Once the path is complete it streams them out fonte-first over a valid/ready interface, so an external consumer receives the route in travel order.

## Interface
- ADDR_WIDTH, 10, node address width; matches the graph memories.
- MAX_CAMINHO, 64, maximum stored nodes (LIFO depth).
- CONT_WIDTH, $clog2(MAX_CAMINHO+1), width of the node counter.

- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- iniciar_in  in  1  one-cycle pulse with the new fonte/destino write; clears block and arms capture.
- no_valido_in  in  1  strobe: one path node on no_endereco_in this cycle.
- no_endereco_in  in  ADDR_WIDTH  path node address (destino first, fonte last).
- caminho_pronto_in  in  1  pulse: path reconstruction finished.
- saida_valido_out  out  1  output node valid.
- saida_endereco_out  out  ADDR_WIDTH  output node address (fonte first).
- saida_ultimo_out  out  1  qualifies the final node (destino).
- saida_pronto_in  in  1  consumer ready.
- ocupado_out  out  1  high whenever state != OCIOSO.
- tamanho_out  out  CONT_WIDTH  nodes captured; held until next iniciar_in.
- overflow_out  out  1  sticky: a node was dropped because the LIFO was full.

## Operation
- States: OCIOSO, CAPTURA, ENVIO. Reset state is OCIOSO.
- OCIOSO:
  - no_valido_in and caminho_pronto_in are ignored.
  - iniciar_in moves to CAPTURA.
- CAPTURA, on no_valido_in:
  - If ptr < MAX_CAMINHO: write mem[ptr] <= no_endereco_in and increment ptr.
  - Otherwise: drop the node and set overflow_out.
- CAPTURA, on caminho_pronto_in:
  - A node strobed in the same cycle is captured first.
  - Go to ENVIO if the resulting ptr > 0; otherwise go to OCIOSO and emit nothing.
- ENVIO (pop-order stream):
  - Output register is loaded with mem[ptr-1] and ptr is decremented.
  - saida_ultimo_out is 1 exactly when the loaded entry is index 0.
  - Transfer occurs when saida_valido_out && saida_pronto_in.
  - On a transfer, the next entry is loaded in the same edge if one remains. Otherwise saida_valido_out drops and the block goes to OCIOSO.
- While saida_valido_out=1 and saida_pronto_in=0: saida_endereco_out and saida_ultimo_out hold stable.
- iniciar_in in any state (highest priority):
  - ptr, tamanho_out, overflow_out and saida_valido_out are cleared.
  - State goes to CAPTURA, including when it arrives mid-ENVIO.
  - No-valid/pronto inputs in that cycle are ignored.
- tamanho_out increments on each accepted capture, saturates at MAX_CAMINHO, and does not decrement during ENVIO.
- No arithmetic beyond the pointer ±1; ptr never wraps (guarded at 0 and at MAX_CAMINHO).

## Timing
- Reset values:
  - saida_valido_out=0, saida_endereco_out=0, saida_ultimo_out=0.
  - ocupado_out=0, tamanho_out=0, overflow_out=0.
  - ptr=0, state OCIOSO.
- Capture: one node per cycle, zero backpressure upstream. A node is stored at the edge sampling no_valido_in.
- ocupado_out rises on the edge after iniciar_in is sampled.
- First output latency:
  - Edge sampling caminho_pronto_in: state becomes ENVIO.
  - Next edge: saida_valido_out=1 with the last-captured node.
- Throughput: one node per cycle while saida_pronto_in is held high. An N-node path drains in N cycles after the first valid.
- saida_valido_out falls on the edge that completes the ultimo transfer; ocupado_out falls on the same edge.
- Memory: a register array or RAM with a registered read is acceptable, provided the cycle behaviour above is met exactly.

## Test plan
- Basic reversal:
  - Stimulus: iniciar, then nodes 0x2A,0x15,0x07,0x03 on consecutive cycles, caminho_pronto with 0x03; saida_pronto_in=1.
  - Response: outputs 0x03,0x07,0x15,0x2A on consecutive cycles; ultimo only on 0x2A; tamanho_out=4.
- Backpressure:
  - Stimulus: same path; saida_pronto_in toggles 1,0,0,1,...
  - Response: each address holds while not ready; no duplicates or losses; order unchanged.
- Overflow:
  - Stimulus: MAX_CAMINHO=4, nodes 1..6, then pronto.
  - Response: overflow_out=1, tamanho_out=4; outputs 4,3,2,1 with ultimo on 1.
- Empty path:
  - Stimulus: iniciar then caminho_pronto with no nodes.
  - Response: saida_valido_out never rises; ocupado_out returns to 0 one edge after pronto.
- Abort mid-ENVIO:
  - Stimulus: 3-node path; after first output transfer, pulse iniciar_in, then a new path 0x10,0x11.
  - Response: valid drops next edge; tamanho_out=0 then 2; outputs 0x11,0x10 only.
- Async reset:
  - Stimulus: assert rst_n=0 mid-CAPTURA between clock edges.
  - Response: all outputs go to their reset values immediately, without waiting for clk.
